// File: rtl/csr_reg_file.sv
// Machine-mode CSR register file: two write ports (ex and interrupt controller),
// two combinational read ports with write forwarding, and a free-running mcycle.
module csr_reg_file #(
  parameter bit MCYCLE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [63:0] waddr_i,
  input  logic [63:0] data_i,
  input  logic [63:0] raddr_i,
  output logic [63:0] data_o,
  input  logic        clint_we_i,
  input  logic [63:0] clint_waddr_i,
  input  logic [63:0] clint_data_i,
  input  logic [63:0] clint_raddr_i,
  output logic [63:0] clint_data_o,
  output logic [63:0] csr_mtvec,
  output logic [63:0] csr_mepc,
  output logic [63:0] csr_mstatus,
  output logic        global_int_en_o
);

  localparam int NREG        = 7;
  localparam int IDX_MSTATUS = 0;
  localparam int IDX_MIE     = 1;
  localparam int IDX_MTVEC   = 2;
  localparam int IDX_MSCRATCH = 3;
  localparam int IDX_MEPC    = 4;
  localparam int IDX_MCAUSE  = 5;
  localparam int IDX_MCYCLE  = 6;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;

  // One-hot select of the writable register at an address; 0 when unimplemented
  // or read-only, so such writes simply never reach any register.
  function automatic logic [NREG-1:0] wr_select(input logic [11:0] addr);
    logic [NREG-1:0] sel;
    sel = '0;
    case (addr)
      ADDR_MSTATUS:  sel[IDX_MSTATUS]  = 1'b1;
      ADDR_MIE:      sel[IDX_MIE]      = 1'b1;
      ADDR_MTVEC:    sel[IDX_MTVEC]    = 1'b1;
      ADDR_MSCRATCH: sel[IDX_MSCRATCH] = 1'b1;
      ADDR_MEPC:     sel[IDX_MEPC]     = 1'b1;
      ADDR_MCAUSE:   sel[IDX_MCAUSE]   = 1'b1;
      ADDR_MCYCLE:   sel[IDX_MCYCLE]   = 1'b1;
      default:       sel = '0;
    endcase
    return sel;
  endfunction

  // Read decode adds the read-only cycle alias onto mcycle.
  function automatic logic [NREG-1:0] rd_select(input logic [11:0] addr);
    logic [NREG-1:0] sel;
    sel = wr_select(addr);
    if (addr == ADDR_CYCLE) begin
      sel[IDX_MCYCLE] = 1'b1;
    end
    return sel;
  endfunction

  logic [63:0]     csr_q   [NREG];
  logic [63:0]     csr_d   [NREG];
  logic [63:0]     fwd_val [NREG];
  logic [NREG-1:0] ex_wsel;
  logic [NREG-1:0] clint_wsel;
  logic [NREG-1:0] ex_rsel;
  logic [NREG-1:0] clint_rsel;

  always_comb begin
    ex_wsel    = '0;
    clint_wsel = '0;
    if (we_i) begin
      ex_wsel = wr_select(waddr_i[11:0]);
    end
    // On a same-address collision the interrupt-controller write is dropped.
    if (clint_we_i) begin
      clint_wsel = wr_select(clint_waddr_i[11:0]) & ~ex_wsel;
    end
  end

  assign ex_rsel    = rd_select(raddr_i[11:0]);
  assign clint_rsel = rd_select(clint_raddr_i[11:0]);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_csr
      // Value this register holds after the edge if written, else its current
      // value; this is also what the read ports forward.
      assign fwd_val[gi] = ex_wsel[gi]    ? data_i       :
                           clint_wsel[gi] ? clint_data_i :
                                            csr_q[gi];
      if (gi == IDX_MCYCLE && MCYCLE_EN) begin : g_count
        assign csr_d[gi] = (ex_wsel[gi] || clint_wsel[gi]) ? fwd_val[gi]
                                                           : csr_q[gi] + 64'd1;
      end else begin : g_hold
        assign csr_d[gi] = fwd_val[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) begin
        csr_q[i] <= '0;
      end else begin
        csr_q[i] <= csr_d[i];
      end
    end
  end

  always_comb begin
    data_o       = '0;
    clint_data_o = '0;
    for (int i = 0; i < NREG; i++) begin
      if (ex_rsel[i]) begin
        data_o = data_o | fwd_val[i];
      end
      if (clint_rsel[i]) begin
        clint_data_o = clint_data_o | fwd_val[i];
      end
    end
    if (rst) begin
      data_o       = '0;
      clint_data_o = '0;
    end
  end

  assign csr_mtvec       = csr_q[IDX_MTVEC];
  assign csr_mepc        = csr_q[IDX_MEPC];
  assign csr_mstatus     = csr_q[IDX_MSTATUS];
  assign global_int_en_o = csr_q[IDX_MSTATUS][3];

  // Address bits above [11:0] are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr_i[63:12], raddr_i[63:12],
                              clint_waddr_i[63:12], clint_raddr_i[63:12]};

endmodule

// File: doc/csr_reg_file.md
# csr_reg_file

Machine-mode CSR register file for the RV64 core. It holds mstatus, mie, mtvec, mscratch, mepc, mcause and a free-running mcycle counter. It arbitrates between two write ports: one from ex (CSR instructions) and one from the interrupt controller's trap/mret sequencer. It serves two combinational read ports and drives the interrupt controller with mtvec, mepc, mstatus and the global interrupt enable.

## Interface
Parameters:
- MCYCLE_EN, 1, 1 = mcycle increments every cycle; 0 = mcycle changes only by software write.

Ports:
- clk  in  1  core clock; one clock domain, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we_i  in  1  ex write enable.
- waddr_i  in  64  ex write address; only bits [11:0] decoded.
- data_i  in  64  ex write data.
- raddr_i  in  64  ex read address; only [11:0] decoded.
- data_o  out  64  ex read data (combinational).
- clint_we_i  in  1  interrupt-controller write enable.
- clint_waddr_i  in  64  interrupt-controller write address; only [11:0] decoded.
- clint_data_i  in  64  interrupt-controller write data.
- clint_raddr_i  in  64  interrupt-controller read address.
- clint_data_o  out  64  interrupt-controller read data (combinational).
- csr_mtvec  out  64  current mtvec.
- csr_mepc  out  64  current mepc.
- csr_mstatus  out  64  current mstatus.
- global_int_en_o  out  1  mstatus[3] (MIE).

## Operation
- Implemented addresses:
  - 0x300 mstatus
  - 0x304 mie
  - 0x305 mtvec
  - 0x340 mscratch
  - 0x341 mepc
  - 0x342 mcause
  - 0xB00 mcycle (read/write)
  - 0xC00 cycle (read-only alias of mcycle)
- All registers are full 64 bits. No WARL masking.
- Unimplemented addresses read 0. Writes to them are dropped.
- Writes to 0xC00 are dropped.
- Write arbitration, applied per cycle:
  - Both ports write the same address: the ex write wins and the clint write is lost.
  - Ports write different addresses: both writes commit in the same cycle.
- mcycle:
  - With MCYCLE_EN=1, mcycle <= mcycle+1 every cycle. Wraps 0xFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
  - A write to 0xB00 in a cycle loads the written value and suppresses that cycle's increment.
- Read ports are combinational with write forwarding:
  - If the read address equals a write address committing this cycle, the port returns that write data. Ex data takes precedence if both ports target the address.
  - Reads of 0xB00 and 0xC00 with no write to 0xB00 pending return the registered mcycle, i.e. the pre-increment value.
  - Reading 0xC00 while 0xB00 is written returns the written value.
- Address decode compares bits [11:0] only. Upper address bits are don't-care, so 0x1300 aliases 0x300.
- The csr_mtvec, csr_mepc and csr_mstatus outputs are registered values with no forwarding. global_int_en_o = csr_mstatus[3].

## Timing
- Reset, when rst=1 at a clock edge: every register, including mcycle, is 0. Consequently csr_mtvec, csr_mepc, csr_mstatus and global_int_en_o are 0 in the cycle after reset.
- During reset the read ports return 0 for all addresses. Writes presented while rst=1 are ignored.
- Write latency:
  - A write presented in cycle N is visible on the direct outputs in cycle N+1.
  - It is visible on the read ports in cycle N via forwarding.
- The interrupt controller's trap sequence writes mepc, mstatus and mcause in consecutive cycles. Each write must be reflected on csr_mstatus/csr_mepc one cycle later, so that its later mtvec/mepc sampling and MIE clear/restore see the updated values.
- Reset asserted mid-sequence: all state returns to 0 on that edge, and any write in that cycle is discarded.
- No handshake: both write ports are fire-and-forget, and both read ports are always valid.

## Test plan
- Reset then idle, MCYCLE_EN=1:
  - All direct outputs are 0 in the first post-reset cycle.
  - A read of 0xC00 after 10 idle cycles returns 10.
- Ex writes 0x305 = 0x8000_0100:
  - data_o with raddr_i=0x305 returns 0x8000_0100 in the same cycle.
  - csr_mtvec = 0x8000_0100 in the next cycle.
- Same-cycle conflict: ex writes 0x341 = 0x1111 and clint writes 0x341 = 0x2222.
  - Next cycle csr_mepc = 0x1111.
- Parallel writes: ex writes 0x340 = 5 and clint writes 0x300 = 0x8 in the same cycle.
  - Both commit.
  - global_int_en_o = 1 next cycle.
- mcycle write: with mcycle near 0x64, write 0xB00 = 0xFFFF_FFFF_FFFF_FFFF.
  - Next cycle the read returns all-ones.
  - One cycle later it returns 0 (wrap).
  - A write to 0xC00 = 7 leaves mcycle incrementing normally.
- Reset mid-trap:
  - clint writes 0x300 = 0x88, then rst=1 in the following cycle while clint writes 0x342 = 11.
  - After reset csr_mstatus = 0, mcause reads 0, and global_int_en_o = 0.
